spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 28 ++
 rtl/spi_slave.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave bundle: serial pins, transmit holding-buffer handshake and
// receive outputs. The slave modport is what spi_slave uses; the master
// modport is the view of whoever drives the pins and the host side.
interface spi_slave_if;
    logic       cpol;
    logic       cpha;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       busy;

    modport slave (
        input  cpol, cpha, sclk, ss_n, mosi, tx_data, tx_wr,
        output miso, miso_oe, tx_ready, rx_data, rx_done_tick, busy
    );

    modport master (
        output cpol, cpha, sclk, ss_n, mosi, tx_data, tx_wr,
        input  miso, miso_oe, tx_ready, rx_data, rx_done_tick, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, oversampling the asynchronous SPI
// pins with the system clock. One-byte transmit holding buffer, MSB-first
// shifting in both directions, back-to-back bytes under one ss_n low.
module spi_slave (
    input  logic        clk,
    input  logic        reset_n,
    spi_slave_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Synchronizers; ss_n stages reset low so that a select already held
    // low across reset is not mistaken for a fresh falling edge.
    logic       sclk_s1_q, sclk_s1_d;
    logic       sclk_s2_q, sclk_s2_d;
    logic       sclk_s3_q, sclk_s3_d;
    logic       ss_s1_q,   ss_s1_d;
    logic       ss_s2_q,   ss_s2_d;
    logic       ss_s3_q,   ss_s3_d;
    logic       mosi_s1_q, mosi_s1_d;
    logic       mosi_s2_q, mosi_s2_d;

    state_e     state_q,   state_d;
    logic [2:0] cnt_q,     cnt_d;
    logic [7:0] rx_sh_q,   rx_sh_d;
    logic [7:0] tx_sh_q,   tx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_done_q, rx_done_d;
    logic [7:0] tx_buf_q,  tx_buf_d;
    logic       tx_ready_q, tx_ready_d;
    logic       miso_oe_q, miso_oe_d;
    logic       busy_q,    busy_d;

    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       lead_s;
    logic       trail_s;
    logic       sample_s;
    logic       shift_s;
    logic       start_s;
    logic       run_s;
    logic       load_s;
    logic       wr_accept_s;
    logic [7:0] load_byte_s;

    // Edge classification and buffer handshake decisions for this cycle.
    always_comb begin
        sclk_rise_s = sclk_s2_q & ~sclk_s3_q;
        sclk_fall_s = ~sclk_s2_q & sclk_s3_q;
        lead_s      = bus.cpol ? sclk_fall_s : sclk_rise_s;
        trail_s     = bus.cpol ? sclk_rise_s : sclk_fall_s;
        sample_s    = bus.cpha ? trail_s : lead_s;
        shift_s     = bus.cpha ? lead_s : trail_s;
        start_s     = (state_q == ST_IDLE) & ss_s3_q & ~ss_s2_q;
        run_s       = (state_q == ST_ACTIVE) & ~ss_s2_q;
        // A load in CPHA=0 happens at select time because the first bit
        // must be on miso before the first (sampling) leading edge.
        load_s      = (start_s & ~bus.cpha) |
                      (run_s & shift_s & (cnt_q == 3'd0));
        load_byte_s = tx_ready_q ? 8'h00 : tx_buf_q;
        // A load frees the buffer in the same cycle, so a coincident write
        // is taken even if the buffer looked full.
        wr_accept_s = bus.tx_wr & (tx_ready_q | load_s);
    end

    // Next-state computation for the synchronizers, FSM and datapath.
    always_comb begin
        sclk_s1_d  = bus.sclk;
        sclk_s2_d  = sclk_s1_q;
        sclk_s3_d  = sclk_s2_q;
        ss_s1_d    = bus.ss_n;
        ss_s2_d    = ss_s1_q;
        ss_s3_d    = ss_s2_q;
        mosi_s1_d  = bus.mosi;
        mosi_s2_d  = mosi_s1_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 3'd0;
                    rx_sh_d = 8'h00;
                    if (!bus.cpha) begin
                        tx_sh_d = load_byte_s;
                    end else begin
                        tx_sh_d = tx_sh_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_s2_q) begin
                    // Deselect: drop any partial byte without reporting it.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    rx_sh_d = 8'h00;
                    tx_sh_d = 8'h00;
                end else if (sample_s) begin
                    rx_sh_d = {rx_sh_q[6:0], mosi_s2_q};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d = {rx_sh_q[6:0], mosi_s2_q};
                        rx_done_d = 1'b1;
                    end else begin
                        rx_data_d = rx_data_q;
                    end
                end else if (shift_s) begin
                    if (cnt_q == 3'd0) begin
                        tx_sh_d = load_byte_s;
                    end else begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (wr_accept_s) begin
            tx_buf_d   = bus.tx_data;
            tx_ready_d = 1'b0;
        end else if (load_s) begin
            tx_ready_d = 1'b1;
        end else begin
            tx_ready_d = tx_ready_q;
        end

        miso_oe_d = (state_d == ST_ACTIVE);
        busy_d    = (state_d == ST_ACTIVE);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            ss_s1_q    <= 1'b0;
            ss_s2_q    <= 1'b0;
            ss_s3_q    <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            rx_sh_q    <= 8'h00;
            tx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_done_q  <= 1'b0;
            tx_buf_q   <= 8'h00;
            tx_ready_q <= 1'b1;
            miso_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sclk_s1_q  <= sclk_s1_d;
            sclk_s2_q  <= sclk_s2_d;
            sclk_s3_q  <= sclk_s3_d;
            ss_s1_q    <= ss_s1_d;
            ss_s2_q    <= ss_s2_d;
            ss_s3_q    <= ss_s3_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            miso_oe_q  <= miso_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.miso         = tx_sh_q[7];
    assign bus.miso_oe      = miso_oe_q;
    assign bus.tx_ready     = tx_ready_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_done_tick = rx_done_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave acting as an SPI master.
module tb_spi_slave;

    localparam int H = 6;   // SPI half period in clk cycles

    logic clk;
    logic reset_n;
    spi_slave_if bus ();

    spi_slave dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         ticks  = 0;
    logic [7:0] tick_rx = 8'h00;
    logic       mid_busy;
    logic       mid_oe;
    logic [7:0] mi0, mi1;

    // Record every completion strobe and the byte shown alongside it.
    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            ticks   = ticks + 1;
            tick_rx = bus.rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] v);
        @(negedge clk);
        bus.tx_data = v;
        bus.tx_wr   = 1'b1;
        @(negedge clk);
        bus.tx_wr   = 1'b0;
    endtask

    task automatic set_mode(input int m);
        bus.cpol = m[1];
        bus.cpha = m[0];
        bus.sclk = m[1];
        idle(8);
    endtask

    // What the master should see on miso: the written byte, or zeros
    // when nothing was written before the load.
    function automatic logic [7:0] model_miso(input bit wr, input logic [7:0] tx);
        return wr ? tx : 8'h00;
    endfunction

    task automatic check_reset_state(input string pfx);
        check({pfx, "_miso"},     {31'd0, bus.miso},         32'd0);
        check({pfx, "_miso_oe"},  {31'd0, bus.miso_oe},      32'd0);
        check({pfx, "_busy"},     {31'd0, bus.busy},         32'd0);
        check({pfx, "_tx_ready"}, {31'd0, bus.tx_ready},     32'd1);
        check({pfx, "_rx_data"},  {24'd0, bus.rx_data},      32'h00);
        check({pfx, "_rx_tick"},  {31'd0, bus.rx_done_tick}, 32'd0);
    endtask

    // One select window: nbytes bytes, optional write of mid_val during
    // byte 0, optional abort after cut_bits bits (by ss_n or by reset).
    task automatic spi_session(input int nbytes, input logic [7:0] mo0, input logic [7:0] mo1,
                               input bit mid_wr, input logic [7:0] mid_val,
                               input int cut_bits, input bit cut_by_reset,
                               output logic [7:0] r0, output logic [7:0] r1);
        logic [7:0] mo;
        logic [7:0] mi;
        bit         stop;
        stop = 1'b0;
        r0 = 8'h00;
        r1 = 8'h00;
        bus.ss_n = 1'b0;
        idle(2 * H);
        for (int b = 0; b < nbytes && !stop; b++) begin
            mo = (b == 0) ? mo0 : mo1;
            mi = 8'h00;
            for (int i = 7; i >= 0 && !stop; i--) begin
                if (cut_bits > 0 && b == 0 && (7 - i) == cut_bits) begin
                    stop = 1'b1;
                end else begin
                    if (mid_wr && b == 0 && i == 5) tx_write(mid_val);
                    if (!bus.cpha) begin
                        bus.mosi = mo[i];
                        idle(H);
                        bus.sclk = ~bus.cpol;
                        mi[i] = bus.miso;
                        idle(H);
                        bus.sclk = bus.cpol;
                    end else begin
                        idle(H);
                        bus.sclk = ~bus.cpol;
                        bus.mosi = mo[i];
                        idle(H);
                        bus.sclk = bus.cpol;
                        mi[i] = bus.miso;
                    end
                    if (b == 0 && i == 7) begin
                        mid_busy = bus.busy;
                        mid_oe   = bus.miso_oe;
                    end
                end
            end
            if (b == 0) r0 = mi; else r1 = mi;
        end
        idle(H);
        if (stop && cut_by_reset) begin
            reset_n = 1'b0;
            idle(2);
            bus.ss_n = 1'b1;
            idle(2);
        end else begin
            bus.ss_n = 1'b1;
            idle(2 * H);
        end
    endtask

    initial begin
        int         t0;
        logic [7:0] prev_rx;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.sclk    = 1'b0;
        bus.ss_n    = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_wr   = 1'b0;
        reset_n     = 1'b0;
        idle(4);
        check_reset_state("reset");
        reset_n = 1'b1;
        idle(6);

        // Mode 0 basic byte
        set_mode(0);
        tx_write(8'hA5);
        check("mode0_tx_ready_full", {31'd0, bus.tx_ready}, 32'd0);
        t0 = ticks;
        spi_session(1, 8'h3C, 8'h00, 1'b0, 8'h00, 0, 1'b0, mi0, mi1);
        check("mode0_miso",     {24'd0, mi0},          32'hA5);
        check("mode0_rx_data",  {24'd0, bus.rx_data},  32'h3C);
        check("mode0_ticks",    ticks - t0,            32'd1);
        check("mode0_tick_rx",  {24'd0, tick_rx},      32'h3C);
        check("mode0_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("mode0_mid_busy", {31'd0, mid_busy},     32'd1);
        check("mode0_mid_oe",   {31'd0, mid_oe},       32'd1);
        check("mode0_end_busy", {31'd0, bus.busy},     32'd0);
        check("mode0_end_oe",   {31'd0, bus.miso_oe},  32'd0);

        // Modes 1..3
        for (int m = 1; m <= 3; m++) begin
            set_mode(m);
            tx_write(8'h81);
            t0 = ticks;
            spi_session(1, 8'h7E, 8'h00, 1'b0, 8'h00, 0, 1'b0, mi0, mi1);
            check($sformatf("mode%0d_miso", m),    {24'd0, mi0},         32'h81);
            check($sformatf("mode%0d_rx_data", m), {24'd0, bus.rx_data}, 32'h7E);
            check($sformatf("mode%0d_ticks", m),   ticks - t0,           32'd1);
        end

        // Two bytes under one select, second byte written after first load
        set_mode(0);
        tx_write(8'h11);
        t0 = ticks;
        spi_session(2, 8'hC7, 8'h5B, 1'b1, 8'h22, 0, 1'b0, mi0, mi1);
        check("two_miso0",   {24'd0, mi0},         32'h11);
        check("two_miso1",   {24'd0, mi1},         32'h22);
        check("two_ticks",   ticks - t0,           32'd2);
        check("two_rx_data", {24'd0, bus.rx_data}, 32'h5B);

        // Nothing written: zeros on miso, receive unaffected
        t0 = ticks;
        spi_session(1, 8'h5A, 8'h00, 1'b0, 8'h00, 0, 1'b0, mi0, mi1);
        check("nowr_miso",    {24'd0, mi0},         32'h00);
        check("nowr_rx_data", {24'd0, bus.rx_data}, 32'h5A);

        // Deselect after 5 bits, then a full byte
        for (int m = 0; m <= 3; m += 3) begin
            set_mode(m);
            prev_rx = bus.rx_data;
            t0 = ticks;
            spi_session(1, 8'hF0, 8'h00, 1'b0, 8'h00, 5, 1'b0, mi0, mi1);
            check($sformatf("abort%0d_ticks", m),   ticks - t0,           32'd0);
            check($sformatf("abort%0d_rx_data", m), {24'd0, bus.rx_data}, {24'd0, prev_rx});
            check($sformatf("abort%0d_busy", m),    {31'd0, bus.busy},    32'd0);
            check($sformatf("abort%0d_oe", m),      {31'd0, bus.miso_oe}, 32'd0);
            tx_write(8'h3E);
            t0 = ticks;
            spi_session(1, 8'hC3, 8'h00, 1'b0, 8'h00, 0, 1'b0, mi0, mi1);
            check($sformatf("after_abort%0d_rx", m),    {24'd0, bus.rx_data}, 32'hC3);
            check($sformatf("after_abort%0d_miso", m),  {24'd0, mi0},         32'h3E);
            check($sformatf("after_abort%0d_ticks", m), ticks - t0,           32'd1);
        end

        // Reset in the middle of a byte, then a clean transfer
        set_mode(0);
        tx_write(8'h9E);
        t0 = ticks;
        spi_session(1, 8'hAA, 8'h00, 1'b0, 8'h00, 3, 1'b1, mi0, mi1);
        check_reset_state("midrst");
        check("midrst_ticks", ticks - t0, 32'd0);
        reset_n = 1'b1;
        idle(8);
        tx_write(8'h4B);
        spi_session(1, 8'hD2, 8'h00, 1'b0, 8'h00, 0, 1'b0, mi0, mi1);
        check("postrst_miso", {24'd0, mi0},         32'h4B);
        check("postrst_rx",   {24'd0, bus.rx_data}, 32'hD2);

        // Randomized single-byte transfers against the model
        for (int k = 0; k < 8; k++) begin
            int         m;
            bit         wr;
            logic [7:0] txb, rxb;
            m   = int'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            txb = 8'($urandom);
            rxb = 8'($urandom);
            set_mode(m);
            if (wr) tx_write(txb);
            t0 = ticks;
            spi_session(1, rxb, 8'h00, 1'b0, 8'h00, 0, 1'b0, mi0, mi1);
            check($sformatf("rand%0d_m%0d_miso", k, m), {24'd0, mi0},          {24'd0, model_miso(wr, txb)});
            check($sformatf("rand%0d_m%0d_rx", k, m),   {24'd0, bus.rx_data},  {24'd0, rxb});
            check($sformatf("rand%0d_m%0d_ticks", k, m), ticks - t0,           32'd1);
            check($sformatf("rand%0d_m%0d_ready", k, m), {31'd0, bus.tx_ready}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
